// File: rtl/config_shift_loader_pkg.sv
// Shared types and derived-size helpers for the configuration shift-chain loader.
package config_shift_loader_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_e;

  function automatic int num_words(input int chain_length, input int word_width);
    return (chain_length + word_width - 1) / word_width;
  endfunction

  // Bits carried by the first (right-aligned) word of a bitstream.
  function automatic int first_bits(input int chain_length, input int word_width);
    return (chain_length % word_width == 0) ? word_width : chain_length % word_width;
  endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Left-justified word shift register with a count of bits still to send from the held word.
module config_word_serializer #(
  parameter int WORD_WIDTH = 8,
  parameter int FIRST_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  first,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  msb,
  output logic                  last_bit
);

  localparam int CW  = $clog2(WORD_WIDTH + 1);
  localparam int PRE = WORD_WIDTH - FIRST_BITS;

  logic [WORD_WIDTH-1:0] sreg;
  logic [CW-1:0]         bits_in_word;

  // A load in the last-bit cycle replaces the outgoing word, so load wins over shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg         <= '0;
      bits_in_word <= '0;
    end else if (load) begin
      sreg         <= first ? (word << PRE) : word;
      bits_in_word <= first ? CW'(FIRST_BITS) : CW'(WORD_WIDTH);
    end else if (shift) begin
      sreg         <= sreg << 1;
      bits_in_word <= bits_in_word - 1'b1;
    end
  end

  assign msb      = sreg[WORD_WIDTH-1];
  assign last_bit = (bits_in_word == CW'(1));

endmodule

// File: rtl/config_shift_loader.sv
// Serialises a word-parallel configuration bitstream MSB-first into a shift chain.
module config_shift_loader
  import config_shift_loader_pkg::*;
#(
  parameter int CHAIN_LENGTH = 8,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  shift_enable,
  output logic                  shift_out,
  output logic                  busy,
  output logic                  done
);

  localparam int FIRST_BITS = first_bits(CHAIN_LENGTH, WORD_WIDTH);
  localparam int TW         = $clog2(CHAIN_LENGTH + 1);

  state_e        state;
  logic [TW-1:0] bits_total;
  logic          first_word;
  logic          more;
  logic          take;
  logic          msb;
  logic          last_bit;

  assign more = bits_total > TW'(1);

  // Outputs decode only registered state; ready also covers the zero-gap prefetch slot.
  assign word_ready   = (state == FETCH) || (state == SHIFT && last_bit && more);
  assign take         = word_valid && word_ready;
  assign shift_enable = (state == SHIFT);
  assign shift_out    = shift_enable & msb;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bits_total <= '0;
      first_word <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= FETCH;
          bits_total <= TW'(CHAIN_LENGTH);
          first_word <= 1'b1;
        end
        FETCH: if (take) begin
          state      <= SHIFT;
          first_word <= 1'b0;
        end
        SHIFT: begin
          bits_total <= bits_total - 1'b1;
          if (!more)                 state <= DONE;
          else if (last_bit && !take) state <= FETCH;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  config_word_serializer #(
    .WORD_WIDTH (WORD_WIDTH),
    .FIRST_BITS (FIRST_BITS)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (take),
    .first    (first_word),
    .shift    (shift_enable),
    .word     (word_data),
    .msb      (msb),
    .last_bit (last_bit)
  );

endmodule

// File: tb/tb_config_shift_loader.sv
// Randomised and directed checks of config_shift_loader against a bitstream-level model.
module tb_config_shift_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int NW = 3;
  localparam int FB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, word_valid = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_ready, shift_enable, shift_out, busy, done;

  config_shift_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .shift_enable(shift_enable), .shift_out(shift_out),
    .busy(busy), .done(done));

  logic       start_a = 1'b0, valid_a = 1'b0;
  logic [7:0] data_a = '0;
  logic       ready_a, se_a, so_a, busy_a, done_a;

  config_shift_loader #(.CHAIN_LENGTH(8), .WORD_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .word_data(data_a), .word_valid(valid_a),
    .word_ready(ready_a), .shift_enable(se_a), .shift_out(so_a), .busy(busy_a), .done(done_a));

  logic       start_b = 1'b0, valid_b = 1'b0;
  logic [3:0] data_b = '0;
  logic       ready_b, se_b, so_b, busy_b, done_b;

  config_shift_loader #(.CHAIN_LENGTH(1), .WORD_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .word_data(data_b), .word_valid(valid_b),
    .word_ready(ready_b), .shift_enable(se_b), .shift_out(so_b), .busy(busy_b), .done(done_b));

  // Attached shift chains: bit k ends up in chain[k] once the load completes.
  logic [CL-1:0] chain;
  logic [7:0]    chain_a;
  logic          chain_b;
  always @(posedge clk) if (shift_enable) chain   <= {chain[CL-2:0], shift_out};
  always @(posedge clk) if (se_a)         chain_a <= {chain_a[6:0], so_a};
  always @(posedge clk) if (se_b)         chain_b <= so_b;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [WW-1:0] words [NW];
  logic [CL-1:0] exp_cfg = '0;

  // Intended configuration: right-aligned first word, later words appended in full.
  function automatic logic [CL-1:0] model_cfg();
    logic [63:0] acc;
    acc = 64'(words[0]) & ((64'd1 << FB) - 64'd1);
    for (int i = 1; i < NW; i++) acc = (acc << WW) | 64'(words[i]);
    return acc[CL-1:0];
  endfunction

  int cyc = 0, sh_idx = 0, gap_cnt = 0, done_cnt = 0;
  int start_cyc = 0, done_cyc = 0, first_sh = 0, last_sh = 0;
  bit exp_busy = 1'b0, prev_se = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_busy = 1'b0;
      prev_se  = 1'b0;
      sh_idx   = 0;
    end else begin
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(prev_se && sh_idx == CL));
      if (!exp_busy) chk("idle_ready", 64'(word_ready), 64'(0));
      if (shift_enable) begin
        if (sh_idx >= CL) chk("shift_overrun", 64'(sh_idx), 64'(CL - 1));
        else              chk("shift_out", 64'(shift_out), 64'(exp_cfg[CL-1-sh_idx]));
        if (sh_idx == 0) first_sh = cyc;
        last_sh = cyc;
        sh_idx++;
      end else if (exp_busy && !done) begin
        gap_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!exp_busy && start) begin
        exp_busy  = 1'b1;
        sh_idx    = 0;
        gap_cnt   = 0;
        done_cnt  = 0;
        start_cyc = cyc;
      end else if (done) begin
        exp_busy = 1'b0;
      end
      prev_se = shift_enable;
    end
  end

  // One full load from words[]; stall_len ready-cycles are withheld before the second word.
  task automatic do_load(input int stall_len, input bit rand_gaps, input int restart_at, input bit held);
    int n, widx, stall_cnt;
    bit hs, rdy, d, ok;
    exp_cfg    = model_cfg();
    widx       = 0;
    stall_cnt  = 0;
    ok         = 1'b0;
    start      = 1'b1;
    word_valid = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    word_data  = words[0];
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      hs  = word_valid && word_ready;
      rdy = word_ready;
      d   = done;
      @(posedge clk); #1;
      start = (n + 1 == restart_at);
      if (hs) widx++;
      if (d) begin ok = 1'b1; break; end
      if (rdy && !word_valid && widx == 1) stall_cnt++;
      if (widx >= NW)                             word_valid = 1'b0;
      else if (widx == 1 && stall_cnt < stall_len) word_valid = 1'b0;
      else word_valid = rand_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      word_data = (word_valid && widx < NW) ? words[widx] : WW'($urandom);
    end
    if (!ok) chk("load_timeout", 64'(n), 64'(0));
    start      = 1'b0;
    word_valid = 1'b0;
    chk("chain", 64'(chain), 64'(exp_cfg));
    chk("shift_total", 64'(sh_idx), 64'(CL));
    chk("done_pulses", 64'(done_cnt), 64'(1));
    if (held) begin
      chk("latency", 64'(done_cyc - start_cyc), 64'(CL + 2));
      chk("contiguous", 64'(last_sh - first_sh + 1), 64'(CL));
    end
    if (stall_len > 0) chk("stall_gap", 64'(gap_cnt - 1 >= stall_len), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq_a;
    bit         sb;
    int         na, nb, pa, pb, dca, dcb;

    #12;
    chk("rst_ready", 64'(word_ready), 64'(0));
    chk("rst_se",    64'(shift_enable), 64'(0));
    chk("rst_so",    64'(shift_out), 64'(0));
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_done",  64'(done), 64'(0));
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Small chains: 8/8 with 0xA5 and 1/4 with 0xE, word_valid held throughout.
    start_a = 1'b1; valid_a = 1'b1; data_a = 8'hA5;
    start_b = 1'b1; valid_b = 1'b1; data_b = 4'hE;
    seq_a = '0; sb = 1'b1; na = 0; nb = 0; pa = 0; pb = 0; dca = -1; dcb = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (se_a) begin seq_a = {seq_a[6:0], so_a}; na++; end
      if (se_b) begin sb = so_b; nb++; end
      if (done_a) begin dca = c; pa++; end
      if (done_b) begin dcb = c; pb++; end
      if (c == 1) begin
        chk("a_fetch_ready", 64'(ready_a), 64'(1));
        chk("a_busy",        64'(busy_a),  64'(1));
        chk("b_fetch_ready", 64'(ready_b), 64'(1));
        chk("b_busy",        64'(busy_b),  64'(1));
      end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
    end
    valid_a = 1'b0; valid_b = 1'b0;
    chk("a_shifts",    64'(na), 64'(8));
    chk("a_bits",      64'(seq_a), 64'(8'hA5));
    chk("a_done_cyc",  64'(dca), 64'(10));
    chk("a_done_cnt",  64'(pa), 64'(1));
    chk("a_chain",     64'(chain_a), 64'(8'hA5));
    chk("b_shifts",    64'(nb), 64'(1));
    chk("b_bit",       64'(sb), 64'(0));
    chk("b_done_cyc",  64'(dcb), 64'(3));
    chk("b_done_cnt",  64'(pb), 64'(1));
    chk("b_chain",     64'(chain_b), 64'(0));

    words[0] = 8'hFB; words[1] = 8'hCD; words[2] = 8'hEF;
    chk("model_cfg", 64'(model_cfg()), 64'(20'hBCDEF));
    do_load(0, 1'b0, 0, 1'b1);
    chk("chain_literal", 64'(chain), 64'(20'hBCDEF));
    do_load(5, 1'b0, 0, 1'b0);
    chk("chain_stall", 64'(chain), 64'(20'hBCDEF));

    // A second start mid-shift, presented with a different stream, must be ignored.
    words[0] = 8'h3C; words[1] = 8'h12; words[2] = 8'h98;
    do_load(0, 1'b0, 8, 1'b1);

    // Asynchronous reset between edges, mid-shift.
    words[0] = WW'($urandom); words[1] = words[0]; words[2] = words[0];
    exp_cfg    = model_cfg();
    start      = 1'b1;
    word_valid = 1'b1;
    word_data  = words[0];
    for (int n = 0; n < 40 && sh_idx < 7; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_ready", 64'(word_ready), 64'(0));
    chk("arst_se",    64'(shift_enable), 64'(0));
    chk("arst_so",    64'(shift_out), 64'(0));
    chk("arst_busy",  64'(busy), 64'(0));
    chk("arst_done",  64'(done), 64'(0));
    word_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) words[i] = WW'($urandom);
    do_load(0, 1'b0, 0, 1'b1);

    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < NW; i++) words[i] = WW'($urandom);
      do_load(($urandom_range(0, 3) == 0) ? 3 : 0, 1'b1,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 12)) : 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
